tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen_if.sv | 24 ++
 rtl/tick_gen.sv | 112 +++++++++++
 tb/tb_tick_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tick_gen_if.sv
// Control/status bundle for tick_gen: the master drives enable, clear and
// period loads; the slave (tick_gen) returns tick pulses, count and error flag.
interface tick_gen_if #(
  parameter int CNT_W = 32
) ();
  logic             en;
  logic             clr;
  logic             div_ld;
  logic [CNT_W-1:0] div_val;
  logic             tick;
  logic             sub_tick;
  logic [CNT_W-1:0] cnt;
  logic             div_err;

  modport master (
    output en, clr, div_ld, div_val,
    input  tick, sub_tick, cnt, div_err
  );

  modport slave (
    input  en, clr, div_ld, div_val,
    output tick, sub_tick, cnt, div_err
  );
endinterface

// File: rtl/tick_gen.sv
// Programmable tick generator with a secondary divide-by-SUB_N tick.
// Optional square-wave output (toggles on every tick) under `TICK_GEN_SQW_EN.
module tick_gen #(
  parameter int CNT_W   = 32,
  parameter int DIV_RST = 8,
  parameter int SUB_N   = 60,
  parameter int SUB_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  tick_gen_if.slave  bus
`ifdef TICK_GEN_SQW_EN
  ,
  output logic       sqw
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_RST  = CNT_W'(DIV_RST);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_N - 1);

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             tick_q, tick_d;
  logic             sub_tick_q, sub_tick_d;
  logic             div_err_q, div_err_d;
  logic             ld_ok;
  logic             ld_zero;
  logic             te;

  // A zero-period request is rejected and leaves counting undisturbed.
  assign ld_ok   = bus.div_ld && (bus.div_val != '0);
  assign ld_zero = bus.div_ld && (bus.div_val == '0);
  assign te      = bus.en && (cnt_q == per_q - CNT_ONE) && !bus.clr && !ld_ok;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    per_d      = per_q;
    cnt_d      = cnt_q;
    sub_cnt_d  = sub_cnt_q;
    tick_d     = 1'b0;
    sub_tick_d = 1'b0;
    div_err_d  = div_err_q;

    if (bus.clr) begin
      cnt_d     = '0;
      sub_cnt_d = '0;
      div_err_d = 1'b0;
    end else begin
      if (ld_zero) div_err_d = 1'b1;

      if (ld_ok) begin
        per_d = bus.div_val;
        cnt_d = '0;
      end else if (te) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (sub_cnt_q == SUB_LAST) begin
          sub_cnt_d  = '0;
          sub_tick_d = 1'b1;
        end else begin
          sub_cnt_d = sub_cnt_q + SUB_W'(1);
        end
      end else if (bus.en) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_q      <= PER_RST;
      cnt_q      <= '0;
      sub_cnt_q  <= '0;
      tick_q     <= 1'b0;
      sub_tick_q <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      per_q      <= per_d;
      cnt_q      <= cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      tick_q     <= tick_d;
      sub_tick_q <= sub_tick_d;
      div_err_q  <= div_err_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.sub_tick = sub_tick_q;
  assign bus.cnt      = cnt_q;
  assign bus.div_err  = div_err_q;

`ifdef TICK_GEN_SQW_EN
  logic sqw_q, sqw_d;

  always_comb begin
    sqw_d = sqw_q;
    if (bus.clr)  sqw_d = 1'b0;
    else if (te)  sqw_d = ~sqw_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sqw_q <= 1'b0;
    else      sqw_q <= sqw_d;
  end

  assign sqw = sqw_q;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: period, sub-tick, loads, enable gaps, clear and reset.
// Square-wave checks are compiled in only when TICK_GEN_SQW_EN is defined.
module tb_tick_gen;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tick_gen_if #(.CNT_W(CNT_W)) bus ();

`ifdef TICK_GEN_SQW_EN
  logic sqw;
`endif

  tick_gen #(
    .CNT_W  (CNT_W),
    .DIV_RST(8),
    .SUB_N  (3),
    .SUB_W  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef TICK_GEN_SQW_EN
    ,
    .sqw(sqw)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CNT_W-1:0] val);
    bus.div_ld  = 1'b1;
    bus.div_val = val;
    step();
    bus.div_ld  = 1'b0;
    bus.div_val = '0;
  endtask

  task automatic clear();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    bus.div_ld  = 1'b0;
    bus.div_val = '0;

    // Reset state
    repeat (2) step();
    check("rst_cnt", 32'(bus.cnt), 0);
    check("rst_tick", 32'(bus.tick), 0);
    check("rst_sub_tick", 32'(bus.sub_tick), 0);
    check("rst_div_err", 32'(bus.div_err), 0);

    // Default period 8: ticks on cycles 8,16,..,40; sub_tick every 3rd tick
    rst    = 1'b1;
    bus.en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      check($sformatf("p8_cnt_%0d", i), 32'(bus.cnt), 32'(i % 8));
      check($sformatf("p8_tick_%0d", i), 32'(bus.tick), 32'(i % 8 == 0));
      check($sformatf("p8_sub_%0d", i), 32'(bus.sub_tick), 32'(i % 24 == 0));
    end

    // Period 2 with SUB_N=3: sub_tick every 6 cycles, coincident with tick
    clear();
    load(2);
    check("ld2_cnt", 32'(bus.cnt), 0);
    check("ld2_tick", 32'(bus.tick), 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("p2_cnt_%0d", i), 32'(bus.cnt), 32'(i % 2));
      check($sformatf("p2_tick_%0d", i), 32'(bus.tick), 32'(i % 2 == 0));
      check($sformatf("p2_sub_%0d", i), 32'(bus.sub_tick), 32'(i % 6 == 0));
    end

    // Load 5 at terminal count 7 of period 8: load wins, no tick
    load(8);
    repeat (7) step();
    check("pre_ld5_cnt", 32'(bus.cnt), 7);
    load(5);
    check("ld5_tick", 32'(bus.tick), 0);
    check("ld5_cnt", 32'(bus.cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("p5_cnt_%0d", i), 32'(bus.cnt), 32'(i % 5));
      check($sformatf("p5_tick_%0d", i), 32'(bus.tick), 32'(i == 5));
    end

    // Zero-period request: flag set, counting continues with period 5
    load(0);
    check("ld0_cnt", 32'(bus.cnt), 1);
    check("ld0_err", 32'(bus.div_err), 1);
    for (int i = 2; i <= 5; i++) begin
      step();
      check($sformatf("p5b_cnt_%0d", i), 32'(bus.cnt), 32'(i % 5));
      check($sformatf("p5b_tick_%0d", i), 32'(bus.tick), 32'(i == 5));
    end

    // Enable gap at cnt=3 for 10 cycles, period 8
    load(8);
    repeat (3) step();
    bus.en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("hold_cnt_%0d", i), 32'(bus.cnt), 3);
      check($sformatf("hold_tick_%0d", i), 32'(bus.tick), 0);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("resume_cnt_%0d", i), 32'(bus.cnt), 32'((3 + i) % 8));
      check($sformatf("resume_tick_%0d", i), 32'(bus.tick), 32'(i == 5));
    end
    check("err_sticky", 32'(bus.div_err), 1);

    // clr beats div_ld at cnt=4: period stays 8, flag cleared
    repeat (4) step();
    check("pre_clr_cnt", 32'(bus.cnt), 4);
    bus.clr     = 1'b1;
    bus.div_ld  = 1'b1;
    bus.div_val = 3;
    step();
    bus.clr     = 1'b0;
    bus.div_ld  = 1'b0;
    bus.div_val = '0;
    check("clr_cnt", 32'(bus.cnt), 0);
    check("clr_err", 32'(bus.div_err), 0);
    check("clr_tick", 32'(bus.tick), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("post_clr_cnt_%0d", i), 32'(bus.cnt), 32'(i % 8));
      check($sformatf("post_clr_tick_%0d", i), 32'(bus.tick), 32'(i == 8));
    end

    // Asynchronous reset mid-operation restores DIV_RST and clears outputs
    load(3);
    load(0);
    check("pre_rst_err", 32'(bus.div_err), 1);
    step();
    step();
    check("pre_rst_tick", 32'(bus.tick), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tick", 32'(bus.tick), 0);
    check("async_rst_cnt", 32'(bus.cnt), 0);
    check("async_rst_err", 32'(bus.div_err), 0);
    check("async_rst_sub", 32'(bus.sub_tick), 0);
    repeat (2) step();
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("rst_per_cnt_%0d", i), 32'(bus.cnt), 32'(i % 8));
      check($sformatf("rst_per_tick_%0d", i), 32'(bus.tick), 32'(i == 8));
    end

    // Period 1: tick every cycle, cnt pinned at 0
    clear();
    load(1);
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("p1_cnt_%0d", i), 32'(bus.cnt), 0);
      check($sformatf("p1_tick_%0d", i), 32'(bus.tick), 1);
      check($sformatf("p1_sub_%0d", i), 32'(bus.sub_tick), 32'(i % 3 == 0));
    end

`ifdef TICK_GEN_SQW_EN
    // Period 4: square wave toggles every 4 cycles
    clear();
    check("sqw_clr", 32'(sqw), 0);
    load(4);
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("sqw_%0d", i), 32'(sqw), 32'((i / 4) % 2));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
